// File: rtl/change_dispenser.sv
// change_dispenser: pays out vend change largest-coin-first over valid/ack, then clears the paid register
module change_dispenser (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] paid_i,
  input  logic [9:0] price_i,
  input  logic       vend_i,
  input  logic       coin_ack_i,
  output logic       coin_valid_o,
  output logic [1:0] coin_type_o,
  output logic [9:0] change_left_o,
  output logic       clear_req_o,
  output logic       busy_o,
  output logic       insufficient_o,
  output logic       done_o
);
  typedef enum logic [2:0] {IDLE, CHECK, REJECT, DISPENSE, CLEAR, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0] paid_l_q, paid_l_d, price_l_q, price_l_d, change_left_q, change_left_d;
  logic [9:0] coin_val;
  assign coin_type_o    = change_left_q >= 10'd100 ? 2'd2 : change_left_q >= 10'd10 ? 2'd1 : 2'd0;
  assign coin_val       = coin_type_o == 2'd2 ? 10'd100 : coin_type_o == 2'd1 ? 10'd10 : 10'd1;
  assign coin_valid_o   = state_q == DISPENSE && change_left_q != 10'd0;
  assign change_left_o  = change_left_q;
  assign clear_req_o    = state_q == CLEAR;
  assign busy_o         = state_q != IDLE;
  assign insufficient_o = state_q == REJECT;
  assign done_o         = state_q == DONE;
  always_comb begin
    state_d       = state_q;
    paid_l_d      = paid_l_q;
    price_l_d     = price_l_q;
    change_left_d = change_left_q;
    case (state_q)
      IDLE: if (vend_i) begin
        paid_l_d  = paid_i;
        price_l_d = price_i;
        state_d   = CHECK;
      end
      CHECK: begin
        state_d       = paid_l_q < price_l_q ? REJECT : DISPENSE;
        change_left_d = paid_l_q < price_l_q ? change_left_q : paid_l_q - price_l_q;
      end
      REJECT:   state_d = IDLE;
      DISPENSE: begin
        state_d       = change_left_q == 10'd0 ? CLEAR : DISPENSE;
        change_left_d = coin_valid_o && coin_ack_i ? change_left_q - coin_val : change_left_q;
      end
      CLEAR:    state_d = paid_i == 10'd0 ? DONE : CLEAR;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      paid_l_q      <= '0;
      price_l_q     <= '0;
      change_left_q <= '0;
    end else begin
      state_q       <= state_d;
      paid_l_q      <= paid_l_d;
      price_l_q     <= price_l_d;
      change_left_q <= change_left_d;
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized vend/handshake stimulus checked against a transaction-level change model
module tb_change_dispenser;
  logic       clk_i = 0;
  logic       reset_i = 1;
  logic [9:0] paid_i = 0;
  logic [9:0] price_i = 0;
  logic       vend_i = 0;
  logic       coin_ack_i = 0;
  logic       coin_valid_o;
  logic [1:0] coin_type_o;
  logic [9:0] change_left_o;
  logic       clear_req_o;
  logic       busy_o;
  logic       insufficient_o;
  logic       done_o;
  int n_cmp = 0;
  int n_bad = 0;
  change_dispenser dut (
    .clk_i(clk_i), .reset_i(reset_i), .paid_i(paid_i), .price_i(price_i),
    .vend_i(vend_i), .coin_ack_i(coin_ack_i), .coin_valid_o(coin_valid_o),
    .coin_type_o(coin_type_o), .change_left_o(change_left_o), .clear_req_o(clear_req_o),
    .busy_o(busy_o), .insufficient_o(insufficient_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check_reset_outputs();
    check("rst_busy", busy_o, 0);
    check("rst_cv", coin_valid_o, 0);
    check("rst_ctype", coin_type_o, 0);
    check("rst_cleft", change_left_o, 0);
    check("rst_clear", clear_req_o, 0);
    check("rst_insuf", insufficient_o, 0);
    check("rst_done", done_o, 0);
  endtask
  function automatic int coin_value(input int t);
    return t == 2 ? 100 : t == 1 ? 10 : 1;
  endfunction
  task automatic do_vend(input int p, input int pr, input int stall, input bit rnd);
    int left, n, k;
    int q[$];
    check("idle_busy", busy_o, 0);
    paid_i = 10'(p);
    price_i = 10'(pr);
    vend_i = 1;
    step();
    vend_i = 0;
    check("chk_busy", busy_o, 1);
    check("chk_cv", coin_valid_o, 0);
    step();
    if (p < pr) begin
      check("rej_insuf", insufficient_o, 1);
      check("rej_cv", coin_valid_o, 0);
      check("rej_clear", clear_req_o, 0);
      step();
      check("rej_insuf_end", insufficient_o, 0);
      check("rej_idle", busy_o, 0);
      check("rej_clear2", clear_req_o, 0);
      return;
    end
    left = p - pr;
    repeat (left / 100) q.push_back(2);
    repeat ((left % 100) / 10) q.push_back(1);
    repeat (left % 10) q.push_back(0);
    n = 0;
    while (q.size() > 0) begin
      check("cv", coin_valid_o, 1);
      check("ctype", coin_type_o, q[0]);
      check("cleft", change_left_o, left);
      check("disp_clear", clear_req_o, 0);
      coin_ack_i = (n >= stall) && (!rnd || $urandom_range(0, 3) != 0);
      vend_i = 1'($urandom_range(0, 1));
      paid_i = 10'($urandom_range(1, 1023));
      step();
      n++;
      if (coin_ack_i) begin
        left -= coin_value(q[0]);
        void'(q.pop_front());
      end
    end
    coin_ack_i = 1'($urandom_range(0, 1));
    vend_i = 0;
    check("zero_cv", coin_valid_o, 0);
    check("zero_cleft", change_left_o, 0);
    check("zero_clear", clear_req_o, 0);
    step();
    coin_ack_i = 0;
    check("clr_req", clear_req_o, 1);
    check("clr_busy", busy_o, 1);
    check("clr_done", done_o, 0);
    check("clr_cv", coin_valid_o, 0);
    k = $urandom_range(0, 3);
    repeat (k) begin
      step();
      check("clr_hold", clear_req_o, 1);
      check("clr_hold_done", done_o, 0);
    end
    paid_i = 0;
    step();
    check("done_pulse", done_o, 1);
    check("done_clear", clear_req_o, 0);
    check("done_busy", busy_o, 1);
    step();
    check("done_end", done_o, 0);
    check("done_idle", busy_o, 0);
  endtask
  initial begin
    step();
    step();
    check_reset_outputs();
    reset_i = 0;
    step();
    do_vend(275, 150, 0, 0);
    do_vend(40, 75, 0, 0);
    do_vend(120, 120, 0, 0);
    do_vend(11, 0, 3, 0);
    do_vend(1023, 0, 0, 1);
    do_vend(0, 0, 0, 0);
    do_vend(0, 1, 0, 0);
    for (int i = 0; i < 40; i++)
      do_vend($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    paid_i = 125;
    price_i = 100;
    vend_i = 1;
    step();
    vend_i = 0;
    step();
    check("pre_rst_cv", coin_valid_o, 1);
    check("pre_rst_cleft", change_left_o, 25);
    coin_ack_i = 0;
    reset_i = 1;
    step();
    check_reset_outputs();
    reset_i = 0;
    step();
    check_reset_outputs();
    do_vend(300, 123, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Vend-side consumer of the accumulated `paid` value. On a vend request it compares `paid` against the item price and rejects the request when funds are short. Otherwise it pays out the change one coin at a time over a valid/ack handshake, largest denomination first, then requests a clear of the paid register and waits until the clear completes. It sits beside `prog_calculator`: it reads `paid`, and its `clear_req` drives the reset-program selection (`rom_num = 3`) upstream.

## Interface
- No parameters; widths fixed at 10 bits to match `paid`.
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `paid`  in  10  current paid total from the calculator, unsigned
- `price`  in  10  selected item price, unsigned; sampled on accepted vend
- `vend`  in  1  vend request; sampled only in IDLE
- `coin_ack`  in  1  coin mechanism accepts presented coin
- `coin_valid`  out  1  coin presented
- `coin_type`  out  2  0 = one, 1 = ten, 2 = hundred (same encoding as `rom_num` 0/1/2); 3 never driven
- `change_left`  out  10  remaining change still to pay out
- `clear_req`  out  1  request reset program on the paid register
- `busy`  out  1  high in every state except IDLE
- `insufficient`  out  1  one-cycle reject pulse
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CHECK, REJECT, DISPENSE, CLEAR, DONE. All outputs are Moore, decoded from state and registers.
- IDLE:
  - `vend` = 1: latch `paid` into `paid_l` and `price` into `price_l`, then go to CHECK.
  - Otherwise stay in IDLE.
- CHECK:
  - `paid_l < price_l`: go to REJECT.
  - Otherwise load `change_left = paid_l - price_l`, then go to DISPENSE.
- REJECT: `insufficient` = 1, then go to IDLE. No coins and no clear; the paid total is kept for further insertion.
- DISPENSE:
  - `change_left == 0`: go to CLEAR (also covers exact payment).
  - Otherwise `coin_valid` = 1, and `coin_type` is chosen combinationally from `change_left`: ≥100 gives hundred, ≥10 gives ten, else one.
  - On a cycle with `coin_valid && coin_ack`: `change_left` decreases by 100, 10 or 1 and the state stays DISPENSE.
  - `coin_type` and `coin_valid` are held stable while `coin_ack` is low.
- CLEAR: `clear_req` = 1, held until `paid == 0` is sampled, then go to DONE. No timeout; the calculator reset program always completes.
- DONE: `done` = 1, then go to IDLE.
- Arithmetic: 10-bit unsigned. The subtraction cannot underflow because it only occurs when `paid_l ≥ price_l`. Decrements never underflow because each denomination is ≤ `change_left`.
- `paid` changes after latching (coins inserted mid-vend) are ignored, except for the zero test in CLEAR.
- `vend` outside IDLE is ignored and not queued.
- `coin_ack` while `coin_valid` = 0 is ignored.

## Timing
- Reset values: state IDLE. `coin_valid`, `clear_req`, `busy`, `insufficient` and `done` are 0. `coin_type` = 0, `change_left` = 0, `paid_l` = 0, `price_l` = 0.
- Reset asserted in any state, including mid-handshake, takes effect at the next edge. Any coin not yet acked is abandoned, and no clear is issued.
- Let the vend be sampled at edge E:
  - E+1: CHECK, `busy` = 1.
  - E+2: REJECT (`insufficient` high for exactly one cycle) or DISPENSE (first `coin_valid` high).
- Each acked coin updates `change_left` at that edge. The next coin is valid in the following cycle, so back-to-back acks give one coin per cycle.
- The cycle after `change_left` reaches 0 is CLEAR. If `paid` already reads 0, DONE follows one cycle later.
- Minimum vend with exact payment: CHECK, DISPENSE, CLEAR (≥1 cycle), DONE. That is 4 cycles of `busy` plus any clear wait.

## Test plan
- `paid`=275, `price`=150, `coin_ack` tied high:
  - coin sequence 100,10,10,1,1,1,1,1 (8 coins, one per cycle);
  - `change_left` steps 125→25→15→5→…→0;
  - then `clear_req` until the model drives `paid`=0, then a `done` pulse.
- `paid`=40, `price`=75: `insufficient` high exactly one cycle at E+2; `coin_valid` and `clear_req` never assert; back in IDLE at E+3.
- `paid`=price=120: zero coins, `clear_req` at E+3, `done` after `paid` reads 0.
- Backpressure, `paid`=11, `price`=0, `coin_ack` low for 3 cycles on the first coin:
  - `coin_valid`=1 and `coin_type`=1 held stable for those cycles;
  - `change_left` stays at 11 until the ack;
  - then one coin of type 0.
- `vend` pulsed repeatedly during DISPENSE and `paid` changed mid-vend: no restart, payout follows the latched values.
- `reset` asserted while a coin is pending (`change_left`=25):
  - next cycle all outputs are at reset values and the state is IDLE;
  - a new `vend` is then accepted normally.
